// File: rtl/rs_enc_ctrl_if.sv
// Streaming handshake between a message source, the RS(255,239)-style encoder and its sink.
interface rs_enc_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/rs_enc_ctrl.sv
// Systematic Reed-Solomon encoder controller: K message symbols pass straight through,
// then 16 parity symbols from a GF(2^8) LFSR (poly 0x11D, roots alpha^0..alpha^15).
module gf_mul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  logic [7:0] acc;
  logic [7:0] x;

  always_comb begin
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    p = acc;
  end
endmodule

// state    | meaning
// S_DATA   | message symbols pass through, parity LFSR absorbs each transfer
// S_PARITY | parity register shifts out p15 first; out_last on the 16th symbol
module rs_enc_ctrl #(
  parameter int K = 239
) (
  input logic           clk,
  input logic           rst_n,
  rs_enc_ctrl_if.slave  bus
);
  localparam int NPAR = 16;

  function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return acc;
  endfunction

  // Coefficients g0..g16 of prod (x + alpha^i), folded at elaboration into a constant table.
  function automatic logic [135:0] gen_poly();
    logic [135:0] g;
    logic [7:0]   root;
    g    = 136'd1;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--)
        g[j*8 +: 8] = g[(j-1)*8 +: 8] ^ gf_mul_c(g[j*8 +: 8], root);
      g[7:0] = gf_mul_c(g[7:0], root);
      root   = gf_mul_c(root, 8'h02);
    end
    return g;
  endfunction

  localparam logic [135:0] GEN = gen_poly();

  typedef enum logic {S_DATA, S_PARITY} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] par  [NPAR];
  logic [7:0] prod [NPAR];
  logic [7:0] fb;
  logic       last_q;
  logic       busy_q;
  logic       xfer_in;

  assign fb      = bus.in_data ^ par[NPAR-1];
  assign xfer_in = (state == S_DATA) && bus.in_valid && bus.out_ready;

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    gf_mul u_mul (
      .a (fb),
      .b (GEN[i*8 +: 8]),
      .p (prod[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_DATA;
      cnt    <= 8'd0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < NPAR; i++) par[i] <= 8'h00;
    end else if (state == S_DATA) begin
      if (xfer_in) begin
        par[0] <= prod[0];
        for (int i = 1; i < NPAR; i++) par[i] <= par[i-1] ^ prod[i];
        busy_q <= 1'b1;
        if (cnt == 8'(K-1)) begin
          state <= S_PARITY;
          cnt   <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end else if (bus.out_ready) begin
      if (cnt == 8'(NPAR-1)) begin
        state  <= S_DATA;
        cnt    <= 8'd0;
        last_q <= 1'b0;
        busy_q <= 1'b0;
        for (int i = 0; i < NPAR; i++) par[i] <= 8'h00;
      end else begin
        par[0] <= 8'h00;
        for (int i = 1; i < NPAR; i++) par[i] <= par[i-1];
        cnt    <= cnt + 8'd1;
        last_q <= (cnt == 8'(NPAR-2));
      end
    end
  end

  // in_ready depends only on out_ready and state, never on the input side.
  assign bus.in_ready  = (state == S_DATA) ? bus.out_ready : 1'b0;
  assign bus.out_valid = (state == S_DATA) ? bus.in_valid  : 1'b1;
  assign bus.out_data  = (state == S_DATA) ? bus.in_data   : par[NPAR-1];
  assign bus.out_last  = last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rs_enc_ctrl.sv
// Directed bench for rs_enc_ctrl: K=4 and K=239 instances checked against a log-table RS model.
module tb_rs_enc_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       sel = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rs_enc_ctrl_if bus4 ();
  rs_enc_ctrl_if bus239 ();

  assign bus4.in_valid    = in_valid;
  assign bus4.in_data     = in_data;
  assign bus4.out_ready   = out_ready;
  assign bus239.in_valid  = in_valid;
  assign bus239.in_data   = in_data;
  assign bus239.out_ready = out_ready;

  rs_enc_ctrl #(.K(4))   u_dut4   (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  rs_enc_ctrl #(.K(239)) u_dut239 (.clk(clk), .rst_n(rst_n), .bus(bus239.slave));

  logic       o_in_ready, o_out_valid, o_out_last, o_busy;
  logic [7:0] o_out_data;
  assign o_in_ready  = sel ? bus239.in_ready  : bus4.in_ready;
  assign o_out_valid = sel ? bus239.out_valid : bus4.out_valid;
  assign o_out_data  = sel ? bus239.out_data  : bus4.out_data;
  assign o_out_last  = sel ? bus239.out_last  : bus4.out_last;
  assign o_busy      = sel ? bus239.busy      : bus4.busy;

  int         exp_t [256];
  int         log_t [256];
  logic [7:0] gen [17];
  logic [7:0] msg [$];
  logic [7:0] exp_cw [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(exp_t[(log_t[a] + log_t[b]) % 255]);
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11d;
    end
    for (int j = 0; j < 17; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int j = 16; j > 0; j--) gen[j] = gen[j-1] ^ gmul(gen[j], 8'(exp_t[i]));
      gen[0] = gmul(gen[0], 8'(exp_t[i]));
    end
  endtask

  // Expected codeword by long division of m(x)*x^16 by g(x).
  task automatic build_exp();
    logic [7:0] rem_q [$];
    logic [7:0] c;
    int k;
    k = msg.size();
    rem_q = msg;
    for (int j = 0; j < 16; j++) rem_q.push_back(8'h00);
    for (int n = 0; n < k; n++) begin
      c = rem_q[n];
      for (int j = 1; j <= 16; j++) rem_q[n+j] = rem_q[n+j] ^ gmul(c, gen[16-j]);
    end
    exp_cw = msg;
    for (int j = 0; j < 16; j++) exp_cw.push_back(rem_q[k+j]);
  endtask

  task automatic make_rand(input int k);
    msg = {};
    for (int i = 0; i < k; i++) msg.push_back(8'($urandom_range(255)));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cw(input int k, input int rdy_pct, input int gap, input int stop_at,
                         input bit nobubble, input string tag);
    int mi, got, cyc, gapcnt, first;
    logic [7:0] held;
    bit hold;
    mi = 0; got = 0; cyc = 0; gapcnt = 0; first = -1; hold = 1'b0; held = 8'h00;
    while (got < stop_at && cyc < 4000) begin
      out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
      if (mi < k) begin
        in_valid = (gapcnt == 0);
        in_data  = in_valid ? msg[mi] : 8'($urandom_range(255));
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = 8'($urandom_range(255));
      end
      @(negedge clk);
      if (hold) chk({tag, "_hold"}, 32'(o_out_data), 32'(held));
      chk({tag, "_in_ready"}, 32'(o_in_ready), (got < k) ? 32'(out_ready) : 32'd0);
      if (got >= k) chk({tag, "_par_valid"}, 32'(o_out_valid), 32'd1);
      chk({tag, "_last"}, 32'(o_out_last), (got == k + 15) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, 32'(o_busy), (got != 0) ? 32'd1 : 32'd0);
      hold = o_out_valid && !out_ready;
      held = o_out_data;
      if (o_out_valid && out_ready) begin
        chk($sformatf("%s_sym%0d", tag, got), 32'(o_out_data), 32'(exp_cw[got]));
        if (first < 0) first = cyc;
        got++;
        if (mi < k) begin
          mi++;
          gapcnt = gap;
        end
      end else if (mi < k && !in_valid && gapcnt > 0) begin
        gapcnt--;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (got < stop_at) chk({tag, "_timeout"}, 32'(got), 32'(stop_at));
    if (nobubble) chk({tag, "_bubble"}, 32'(first), 32'd0);
  endtask

  task automatic idle_check(input string tag);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    chk({tag, "_idle_last"}, 32'(o_out_last), 32'd0);
    chk({tag, "_idle_valid"}, 32'(o_out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_impulse();
    msg    = '{8'h00, 8'h00, 8'h00, 8'h01};
    exp_cw = msg;
    for (int j = 15; j >= 0; j--) exp_cw.push_back(gen[j]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();

    // Reset: pass-through outputs, registered outputs low
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'ha5; out_ready = 1'b0; sel = 1'b0;
    #12;
    chk("rst_in_ready0", 32'(o_in_ready), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd1);
    chk("rst_out_data", 32'(o_out_data), 32'ha5);
    chk("rst_last", 32'(o_out_last), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready1", 32'(o_in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All-zero message, hand-computed: 20 zeros
    msg    = '{8'h00, 8'h00, 8'h00, 8'h00};
    exp_cw = {};
    for (int i = 0; i < 20; i++) exp_cw.push_back(8'h00);
    send_cw(4, 100, 0, 20, 1'b0, "zero");
    idle_check("zero");

    // Impulse message: parity equals g15..g0
    load_impulse();
    send_cw(4, 100, 0, 20, 1'b0, "impulse");
    idle_check("impulse");

    // Input stalls of 3 cycles between message symbols
    make_rand(4);
    build_exp();
    send_cw(4, 100, 3, 20, 1'b0, "stall");
    idle_check("stall");

    // Backpressure on the short codeword
    for (int r = 0; r < 2; r++) begin
      make_rand(4);
      build_exp();
      send_cw(4, 40, 0, 20, 1'b0, $sformatf("bp4_%0d", r));
    end
    idle_check("bp4");

    // Reset after the 5th parity symbol, then an impulse must come out clean
    make_rand(4);
    build_exp();
    send_cw(4, 100, 0, 4 + 5, 1'b0, "abort");
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_last", 32'(o_out_last), 32'd0);
    chk("abort_valid", 32'(o_out_valid), 32'd0);
    chk("abort_in_ready", 32'(o_in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_impulse();
    send_cw(4, 100, 0, 20, 1'b0, "post_abort");
    idle_check("post_abort");

    // Full-length codewords back to back, then under backpressure
    sel = 1'b1;
    do_reset();
    make_rand(239);
    build_exp();
    send_cw(239, 100, 0, 255, 1'b0, "b2b_a");
    make_rand(239);
    build_exp();
    send_cw(239, 100, 0, 255, 1'b1, "b2b_b");
    idle_check("b2b");

    make_rand(239);
    build_exp();
    send_cw(239, 50, 0, 255, 1'b0, "bp239");
    idle_check("bp239");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
